// File: rtl/rv_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding and the default sync word.
package rv_loader_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      FAIL  = 2'd3
   } loader_state_t;

   // Start/end sync word; the top truncates or zero-extends it to WORD_W.
   localparam logic [63:0] DEFAULT_MAGIC = 64'h0000_0000_DEAD_BEEF;

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter used as the inter-byte watchdog of the loader.
// expired is high whenever the count has reached zero.
module loader_timeout #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: hunts for a sync word, assembles little-endian
// words, writes them to memory, and stops on a second sync word.
module prog_loader
   import rv_loader_pkg::*;
#(
   parameter int                WORD_W  = 32,
   parameter int                ADDR_W  = 12,
   parameter logic [WORD_W-1:0] MAGIC   = DEFAULT_MAGIC[WORD_W-1:0],
   parameter int                TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              abort,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              prog_active,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam int BYTES = WORD_W / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   loader_state_t     state, state_next;
   logic [WORD_W-1:0] hunt_reg, hunt_shift;
   logic [WORD_W-1:0] asm_reg, word_full;
   logic [IDX_W-1:0]  byte_idx;
   logic              xfer, last_byte;
   logic              det_start, take_byte, word_end, word_data;
   logic              wr_ack, wrap, tmo, tmo_expired;

   assign rx_ready    = (state == HUNT) || (state == LOAD);
   assign mem_wen     = (state == WRITE);
   assign prog_active = (state == LOAD) || (state == WRITE);
   assign xfer        = rx_valid && rx_ready;

   // Event strobes; abort masks every one of them so it wins any collision.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      hunt_shift = (hunt_reg >> 8) | (WORD_W'(rx_data) << (WORD_W - 8));
      word_full  = asm_reg;
      for (int b = 0; b < BYTES; b++) begin
         if (byte_idx == IDX_W'(b)) word_full[8*b +: 8] = rx_data;
      end
      last_byte = (byte_idx == IDX_W'(BYTES - 1));
      det_start = !abort && (state == HUNT) && xfer && (hunt_shift == MAGIC);
      take_byte = !abort && (state == LOAD) && xfer;
      word_end  = take_byte && last_byte && (word_full == MAGIC);
      word_data = take_byte && last_byte && (word_full != MAGIC);
      wr_ack    = !abort && (state == WRITE) && mem_ready;
      wrap      = wr_ack && (mem_addr == '1);
      tmo       = !abort && (state == LOAD) && !xfer && tmo_expired;
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = HUNT;
      end else begin
         case (state)
            HUNT:    if (det_start) state_next = LOAD;
            LOAD: begin
               if (word_end)       state_next = HUNT;
               else if (word_data) state_next = WRITE;
               else if (tmo)       state_next = FAIL;
            end
            WRITE:   if (wr_ack) state_next = wrap ? FAIL : LOAD;
            FAIL:    state_next = HUNT;
            default: state_next = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) state <= HUNT;
      else      state <= state_next;
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         hunt_reg   <= '0;
         asm_reg    <= '0;
         byte_idx   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         err        <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= word_end;
         if (abort) begin
            hunt_reg <= '0;
            byte_idx <= '0;
         end else begin
            if ((state == HUNT) && xfer) hunt_reg <= det_start ? '0 : hunt_shift;
            if (det_start) begin
               byte_idx   <= '0;
               mem_addr   <= '0;
               word_count <= '0;
               err        <= 1'b0;
            end
            if (take_byte) begin
               asm_reg  <= word_full;
               byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
            if (word_data) mem_wdata <= word_full;
            if (wr_ack) begin
               mem_addr   <= mem_addr + 1'b1;
               word_count <= word_count + 1'b1;
            end
            // A stalled partial word is discarded; the last wrapped write still lands.
            if (tmo) byte_idx <= '0;
            if (tmo || wrap) err <= 1'b1;
         end
      end
   end

   // Reloaded while hunting and on each byte; frozen while a write is stalled.
   loader_timeout #(
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .Rst      (Rst),
      .load     ((state == HUNT) || take_byte),
      .load_val (CNT_W'(TIMEOUT)),
      .en       (state == LOAD),
      .expired  (tmo_expired)
   );

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, giving the memory word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving the word-address width.
REQ-003 The block SHALL have parameter MAGIC, default 'hDEADBEEF zero-extended to WORD_W, giving the start/end sync word.
REQ-004 The block SHALL have parameter TIMEOUT, default 100000, giving the maximum clk cycles between bytes while loading.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: the byte source has a byte.
REQ-008 The block SHALL have port rx_data, input, 8 bits: the received byte.
REQ-009 The block SHALL have port rx_ready, output, 1 bit: the loader accepts a byte; a byte transfers when rx_valid and rx_ready are both 1 at a clk edge.
REQ-010 The block SHALL have port abort, input, 1 bit: synchronous abort request.
REQ-011 The block SHALL have port mem_wen, output, 1 bit: memory write request.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: the word address.
REQ-013 The block SHALL have port mem_wdata, output, WORD_W bits: the write data.
REQ-014 The block SHALL have port mem_ready, input, 1 bit: the memory accepts the write this cycle.
REQ-015 The block SHALL have port prog_active, output, 1 bit: load in progress; the CPU is held in reset while it is 1.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse on a successful load.
REQ-017 The block SHALL have port err, output, 1 bit: sticky error flag.
REQ-018 The block SHALL have port word_count, output, ADDR_W+1 bits: the number of words written in the current or last load.

Function
REQ-019 The state machine SHALL have the states HUNT, LOAD, WRITE and FAIL.
REQ-020 rx_ready SHALL be 1 only in HUNT and LOAD.
REQ-021 In HUNT, each accepted byte SHALL be shifted into a WORD_W hunt register from the MSB side (little-endian: the first byte ends up as the LSB).
REQ-022 In HUNT, when the updated hunt register equals MAGIC, the block SHALL go to LOAD on the next cycle, set prog_active=1, mem_addr=0, word_count=0 and byte index=0, and clear err.
REQ-023 In LOAD, the accepted byte with index k SHALL be placed in assembly bits [8k+7:8k]; the byte index SHALL wrap to 0 after WORD_W/8 bytes.
REQ-024 When a word completes and equals MAGIC, the block SHALL pulse done for 1 cycle, clear prog_active and return to HUNT with the hunt register cleared; mem_wen SHALL NOT be asserted for that word.
REQ-025 When a word completes and does not equal MAGIC, the block SHALL enter WRITE, and mem_wen SHALL be 1 on the cycle after the last byte is accepted (latency 1).
REQ-026 In WRITE, mem_wen, mem_addr and mem_wdata SHALL be held stable until mem_ready=1.
REQ-027 On the cycle mem_ready=1 in WRITE, the block SHALL increment mem_addr and word_count and return to LOAD; mem_wen SHALL be 0 on the next cycle.
REQ-028 If mem_addr wraps from 2^ADDR_W-1 to 0 on a write, the block SHALL go to FAIL (overflow); that last word SHALL still be written.
REQ-029 In LOAD, a cycle counter SHALL reset on every accepted byte; when it reaches TIMEOUT the block SHALL go to FAIL, discarding any partial word.
REQ-030 In FAIL, the block SHALL set err=1, clear prog_active, and go to HUNT after 1 cycle; err SHALL stay 1 until the next start MAGIC is detected.
REQ-031 abort=1 SHALL force HUNT on the next edge from any state, with mem_wen=0, prog_active=0, done=0 and err unchanged.
REQ-032 abort SHALL take priority over a simultaneous byte transfer, a mem_ready, or a MAGIC match.
REQ-033 A data word equal to MAGIC SHALL always be treated as the end marker; the block SHALL NOT provide any escape mechanism.

Reset
REQ-034 While Rst=0, the block SHALL immediately force: state=HUNT, rx_ready=1, mem_wen=0, mem_addr=0, mem_wdata=0, prog_active=0, done=0, err=0, word_count=0, hunt register=0, byte index=0, timeout counter=0.
REQ-035 Reset asserted during LOAD or WRITE SHALL drop an in-flight write without completing it.
REQ-036 After Rst returns to 1, the first byte SHALL be acceptable on the first clk edge.

Structure
REQ-037 The state enum and the default MAGIC value SHALL live in the shared package rv_loader_pkg.
REQ-038 The block SHALL contain one sub-module, loader_timeout (a loadable down-counter with an expired output), instantiated once.

Verification
REQ-039 Scenario 1: bytes EF BE AD DE, 13 00 00 00, 93 00 10 00, EF BE AD DE with mem_ready tied to 1 -> writes 0x00000013 at address 0 and 0x00100093 at address 1, done pulses once, word_count=2, err=0.
REQ-040 Scenario 2: garbage bytes 11 EF EF BE AD DE before the program -> the hunt aligns on the magic, and the first write is at address 0.
REQ-041 Scenario 3: mem_ready held at 0 for 5 cycles during a write -> mem_wen, mem_addr and mem_wdata are stable for those 5 cycles, and rx_ready=0 throughout.
REQ-042 Scenario 4: TIMEOUT=50, two bytes of a word sent then idle -> err=1 and prog_active=0 at cycle 51 after the last byte, with no write.
REQ-043 Scenario 5: ADDR_W=2 and 5 data words -> 4 writes occur, then err=1 and done=0.
REQ-044 Scenario 6: abort, or Rst=0, asserted in WRITE with mem_ready=0 -> mem_wen=0 on the next cycle (immediately for Rst), the block is in HUNT, and a fresh load then succeeds from address 0.
